// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and iteration default for the HI/LO multiply/divide unit
package muldiv_pkg;
    localparam int MD_ITER_DEFAULT = 32;
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: 64-bit accumulator with one shift-add multiply step and one restoring divide step per cycle
module muldiv_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step_mul,
    input  logic        step_div,
    input  logic [63:0] load_acc,
    input  logic [31:0] load_b,
    output logic [63:0] acc
);
    logic [31:0] b_q;
    logic [32:0] sum, diff;
    logic [63:0] mul_nxt, div_nxt;
    always_comb begin
        sum     = {1'b0, acc[63:32]} + {1'b0, b_q};
        diff    = acc[63:31] - {1'b0, b_q};
        mul_nxt = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
        div_nxt = diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            b_q <= '0;
        end else if (load) begin
            acc <= load_acc;
            b_q <= load_b;
        end else if (step_mul) begin
            acc <= mul_nxt;
        end else if (step_div) begin
            acc <= div_nxt;
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide sequencer; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MD_ITER = MD_ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2(MD_ITER + 1);
`ifdef MULDIV_FAST_MUL_EN
    localparam md_state_t MUL_NEXT = FIX;
    logic [63:0] ax, bx;
`else
    localparam md_state_t MUL_NEXT = MUL;
`endif
    md_state_t state, state_n;
    logic [CW-1:0] counter;
    logic sgn, is_mul, is_div, dz, accept, load, fix_mul, neg_hi, neg_lo, neg_mul;
    logic [31:0] mag_a, mag_b, res_hi, res_lo;
    logic [63:0] acc, load_acc, res;
    always_comb begin
        sgn    = op == MD_MULT || op == MD_DIV;
        is_mul = op == MD_MULT || op == MD_MULTU;
        is_div = op == MD_DIV || op == MD_DIVU;
        dz     = b == '0;
        accept = start && state == IDLE;
        mag_a  = sgn && a[31] ? -a : a;
        mag_b  = sgn && b[31] ? -b : b;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    always_comb begin
        state_n = state == FIX ? IDLE :
                  (state == MUL || state == DIV) ? (counter == CW'(1) ? FIX : state) :
                  !accept ? IDLE :
                  is_mul ? MUL_NEXT :
                  is_div ? (dz ? FIX : DIV) : IDLE;
    end
    always_comb begin
        busy     = state != IDLE;
        stall_md = md_use_D && (busy || (start && op <= MD_DIVU));
        load     = accept && (is_mul || is_div);
`ifdef MULDIV_FAST_MUL_EN
        ax       = {{32{sgn && a[31]}}, a};
        bx       = {{32{sgn && b[31]}}, b};
        load_acc = is_mul ? ax * bx : dz ? {a, 32'hFFFF_FFFF} : {32'b0, mag_a};
        neg_mul  = 1'b0;
`else
        load_acc = is_div && dz ? {a, 32'hFFFF_FFFF} : {32'b0, mag_a};
        neg_mul  = sgn && (a[31] ^ b[31]);
`endif
        res_hi   = neg_hi ? -acc[63:32] : acc[63:32];
        res_lo   = neg_lo ? -acc[31:0] : acc[31:0];
        res      = fix_mul ? (neg_lo ? -acc : acc) : {res_hi, res_lo};
    end
    // Divide by zero preloads {a, all-ones} with no negation so FIX writes it unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            counter <= '0;
            fix_mul <= 1'b0;
            neg_hi  <= 1'b0;
            neg_lo  <= 1'b0;
        end else begin
            if (load) begin
                counter <= CW'(MD_ITER);
                fix_mul <= is_mul;
                neg_hi  <= is_div && !dz && sgn && a[31];
                neg_lo  <= is_mul ? neg_mul : !dz && sgn && (a[31] ^ b[31]);
            end else if (state == MUL || state == DIV) begin
                counter <= counter - 1'b1;
            end
            if (state == FIX) {hi, lo} <= res;
            else if (accept && op == MD_MTHI) hi <= a;
            else if (accept && op == MD_MTLO) lo <= a;
        end
    end
    muldiv_iter u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step_mul (state == MUL),
        .step_div (state == DIV),
        .load_acc (load_acc),
        .load_b   (mag_b),
        .acc      (acc)
    );
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vector bench for the HI/LO multiply/divide sequencer
module tb_muldiv_ctrl;
    localparam int ITER = 32;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, md_use_D = 1'b0;
    logic [2:0] op = 3'd6;
    logic [31:0] a = '0, b = '0;
    logic busy, stall_md;
    logic [31:0] hi, lo;
    int total = 0, bad = 0;
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t v[13];
    muldiv_ctrl #(.MD_ITER(ITER)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic int exp_busy(input logic [2:0] o, input logic [31:0] d);
`ifdef MULDIV_FAST_MUL_EN
        if (o <= 3'd1) return 1;
`else
        if (o <= 3'd1) return ITER + 1;
`endif
        if (o <= 3'd3) return d == 0 ? 1 : ITER + 1;
        return 0;
    endfunction
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
    endtask
    task automatic wait_idle(inout int n);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask
    initial begin
        int n;
        v[0]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE};
        v[1]  = '{3'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
        v[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[3]  = '{3'd3, 32'd5,         32'd0,          32'h0000_0005, 32'hFFFF_FFFF};
        v[4]  = '{3'd4, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF};
        v[5]  = '{3'd5, 32'h0000_CAFE, 32'd9,          32'h0000_1234, 32'h0000_CAFE};
        v[6]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
        v[7]  = '{3'd3, 32'd100,       32'd7,          32'h0000_0002, 32'h0000_000E};
        v[8]  = '{3'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
        v[9]  = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD};
        v[10] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        v[11] = '{3'd6, 32'h1111_1111, 32'h2222_2222,  32'hFFFF_FFFE, 32'h0000_0001};
        v[12] = '{3'd2, 32'hFFFF_FFF8, 32'd0,          32'hFFFF_FFF8, 32'hFFFF_FFFF};
        @(negedge clk);
        @(negedge clk);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset stall", {31'b0, stall_md}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 13; i++) begin
            issue(v[i].op, v[i].a, v[i].b);
            n = 0;
            wait_idle(n);
            chk($sformatf("vec%0d busy cycles", i), n, exp_busy(v[i].op, v[i].b));
            chk($sformatf("vec%0d hi", i), hi, v[i].hi);
            chk($sformatf("vec%0d lo", i), lo, v[i].lo);
        end
        // stall logic in idle: only mult/div ops with a valid start request a stall
        @(negedge clk);
        md_use_D = 1'b1; op = 3'd2; a = 32'd1; b = 32'd1; start = 1'b1;
        #1 chk("stall idle div", {31'b0, stall_md}, 32'd1);
        op = 3'd6;
        #1 chk("stall idle nop", {31'b0, stall_md}, 32'd0);
        start = 1'b0; md_use_D = 1'b0;
        // DIV 100/3 with a stall probe at T+10 and a stray start pulse mid-operation
        issue(3'd2, 32'd100, 32'd3);
        repeat (4) @(negedge clk);
        op = 3'd4; a = 32'h5555_5555; b = 32'd9; start = 1'b1;
        @(negedge clk);
        op = 3'd1;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        repeat (3) @(negedge clk);
        md_use_D = 1'b1;
        #1 chk("stall busy use", {31'b0, stall_md}, 32'd1);
        md_use_D = 1'b0;
        #1 chk("stall busy nouse", {31'b0, stall_md}, 32'd0);
        n = 9;
        wait_idle(n);
        chk("div busy cycles w/ stray start", n, ITER + 1);
        chk("div 100/3 hi", hi, 32'd1);
        chk("div 100/3 lo", lo, 32'd33);
        // abort mid-operation
        issue(3'd1, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        issue(3'd1, 32'd3, 32'd5);
        n = 0;
        wait_idle(n);
        chk("post abort busy cycles", n, exp_busy(3'd1, 32'd5));
        chk("post abort hi", hi, 32'd0);
        chk("post abort lo", lo, 32'd15);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the pipeline's HI/LO multiply/divide resource. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs the iterative shift-add or restoring-divide datapath for the required cycles. It owns the HI/LO registers and raises a stall request to the hazard unit while any ID-stage HI/LO-using instruction would observe an unfinished result.

## Interface
Parameters:
- MD_ITER, 32, iteration count for the iterative multiply and divide

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- start  in  1  EX-stage multiply/divide/move op valid this cycle
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-ops
- a  in  32  rs operand, EX stage
- b  in  32  rt operand, EX stage
- md_use_D  in  1  ID-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in progress
- stall_md  out  1  stall request to the hazard unit
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset: state IDLE; busy=0; hi=0; lo=0; counter=0.
- FSM states:
  - IDLE: accepts `start`.
  - MUL, DIV: iterating.
  - FIX: sign correction and HI/LO write. FIX always returns to IDLE.
- IDLE with start:
  - MTHI: hi<=a. MTLO: lo<=a. Either one completes in the same cycle and stays in IDLE.
  - MULT/MULTU: latch operands (magnitudes if signed, with result sign recorded), counter<=MD_ITER, go to MUL.
  - DIV/DIVU with b≠0: latch operands (magnitudes if signed, with result signs recorded), counter<=MD_ITER, go to DIV.
  - DIV/DIVU with b==0: go directly to FIX with hi<=a, lo<=32'hFFFFFFFF.
  - op 6–7: ignored.
- MUL: one shift-add step per cycle on a 64-bit accumulator. Go to FIX when the counter reaches 1.
- DIV: one restoring step per cycle producing a 32-bit quotient and remainder. Go to FIX when the counter reaches 1.
- FIX: write hi and lo.
  - Multiply: {hi,lo} = signed/unsigned 64-bit product.
  - Divide: lo = quotient, hi = remainder.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- busy = (state != IDLE).
- stall_md = md_use_D & (busy | (start & op<=3)). Combinational.
- start while busy: ignored. The hazard unit prevents this; the bench checks that it has no effect.
- reset mid-operation: aborts the operation; next cycle is IDLE with hi=lo=0.

## Timing
- start sampled at cycle T.
- MTHI/MTLO: new value visible at T+1. busy stays 0.
- MUL/DIV: busy=1 for cycles T+1..T+MD_ITER+1.
  - The last of these cycles is FIX.
  - hi/lo are updated on the edge ending FIX; the new value is visible at T+MD_ITER+2 (T+34 by default).
  - busy=0 in that same cycle.
- Divide by zero: busy=1 at T+1 only (FIX); result visible at T+2.
- hi/lo hold their value throughout MUL/DIV. Intermediate values are never exposed.
- stall_md has zero latency from its inputs.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU compute the full product with a single-cycle multiplier and go directly from IDLE to FIX.
  - busy is high for T+1 only; result is visible at T+2.
  - DIV timing is unchanged.
- MULDIV_FAST_MUL_EN undefined: iterative multiply as described in Operation and Timing (busy for MD_ITER+1 cycles).

## Structure
- Shared package `muldiv_pkg` holds:
  - op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO)
  - state encodings (IDLE, MUL, DIV, FIX)
  - the MD_ITER default
- Sub-module `muldiv_iter` holds the datapath:
  - 64-bit accumulator/remainder register
  - one-step shift-add and one-step restoring-subtract logic
- `muldiv_ctrl` holds:
  - the FSM and counter
  - sign bookkeeping and FIX-stage negation
  - hi/lo registers and the stall logic

## Test plan
- Reset: assert reset 2 cycles -> busy=0, stall_md=0, hi=0, lo=0.
- MULTU a=0xFFFFFFFF b=2 at T -> busy high T+1..T+33; at T+34 hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=0xFFFFFFFD (−3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - With MULDIV_FAST_MUL_EN the same result is visible at T+2.
- DIV a=0xFFFFFFF9 (−7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Division by zero and MTHI:
  - DIVU a=5 b=0 -> busy only at T+1; at T+2 hi=5, lo=0xFFFFFFFF.
  - Then MTHI a=0x1234 -> hi=0x1234 next cycle, lo unchanged.
- Stall and abort:
  - DIV in progress with md_use_D=1 at cycle T+10 -> stall_md=1; with md_use_D=0 -> stall_md=0.
  - reset at T+10 -> busy=0, hi=lo=0 at T+11.
  - A start pulse during busy -> no change to the result.
